// File: rtl/uart_pkg.sv
// Shared types and helpers for the word-wide UART transmitter.
package uart_pkg;

    localparam int BITS_PER_BYTE = 8;

    typedef enum logic [2:0] {
        IDLE,
        POP,
        LATCH,
        START,
        DATA,
        STOP
    } uart_state_t;

    // Whole clock cycles per serial bit; the remainder is dropped.
    function automatic int calc_clks_per_bit(input int clk_freq, input int baud);
        return clk_freq / baud;
    endfunction

endpackage

// File: rtl/uart_tx_word_if.sv
// FIFO read-side handshake between the transmitter (master) and the FIFO (slave).
interface uart_tx_word_if #(
    parameter int DATA_LEN = 16
);
    logic                fifo_empty;
    logic [DATA_LEN-1:0] fifo_data;
    logic                read_en;

    modport master (output read_en, input fifo_empty, input fifo_data);
    modport slave  (input read_en, output fifo_empty, output fifo_data);
endinterface

// File: rtl/uart_baud_tick.sv
// Bit-period counter: restarts from zero on every FSM state change and
// flags the last cycle of each bit period.
module uart_baud_tick #(
    parameter int CLKS_PER_BIT = 434
) (
    input  logic clk,
    input  logic reset,
    input  logic restart,
    output logic bit_tick
);
    localparam int CNT_W = (CLKS_PER_BIT > 1) ? $clog2(CLKS_PER_BIT) : 1;
    localparam logic [CNT_W-1:0] LAST = CNT_W'(CLKS_PER_BIT - 1);

    logic [CNT_W-1:0] cnt_q, cnt_d;

    assign bit_tick = (cnt_q == LAST);

    // Next count: wrap at the end of a bit period so bits stay back to back.
    always_comb begin
        cnt_d = cnt_q + CNT_W'(1);
        if (restart || bit_tick) begin
            cnt_d = '0;
        end
    end

    // Counter register.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            cnt_q <= '0;
        end else begin
            cnt_q <= cnt_d;
        end
    end
endmodule

// File: rtl/uart_tx_word.sv
// 8N1 transmitter that pops one word from a FIFO and sends it LSB byte first.
//
// state | meaning
// IDLE  | line high, waiting for the FIFO to be non-empty
// POP   | read_en high for exactly this cycle
// LATCH | FIFO data is valid, capture the word
// START | start bit (low)
// DATA  | eight data bits, LSB first
// STOP  | STOP_BITS stop bits, then next byte or back to IDLE
module uart_tx_word
    import uart_pkg::*;
#(
    parameter int CLK_FREQ     = 50_000_000,
    parameter int BAUD         = 115_200,
    parameter int DATA_LEN     = 16,
    parameter int STOP_BITS    = 1,
    parameter int CLKS_PER_BIT = calc_clks_per_bit(CLK_FREQ, BAUD)
) (
    input  logic                  clk,
    input  logic                  reset,
    uart_tx_word_if.master        fifo,
    output logic                  tx,
    output logic                  busy,
    output logic                  word_done
);
    localparam int NBYTES = DATA_LEN / BITS_PER_BYTE;
    localparam int BIDX_W = (NBYTES > 1) ? $clog2(NBYTES) : 1;
    localparam logic [BIDX_W-1:0] LAST_BYTE = BIDX_W'(NBYTES - 1);
    localparam logic [2:0]        LAST_STOP = 3'(STOP_BITS - 1);

    if (DATA_LEN == 0 || (DATA_LEN % BITS_PER_BYTE) != 0) begin : g_bad_len
        $error("uart_tx_word: DATA_LEN must be a non-zero multiple of 8");
    end
    if (STOP_BITS < 1 || STOP_BITS > 2) begin : g_bad_stop
        $error("uart_tx_word: STOP_BITS must be 1 or 2");
    end
    if (CLKS_PER_BIT < 2) begin : g_bad_cpb
        $error("uart_tx_word: CLKS_PER_BIT must be at least 2");
    end

    uart_state_t         state_q, state_d;
    logic [DATA_LEN-1:0] word_q, word_d;
    logic [7:0]          shift_q, shift_d;
    logic [BIDX_W-1:0]   byte_idx_q, byte_idx_d;
    logic [2:0]          bit_idx_q, bit_idx_d;
    logic                tx_q, tx_d;
    logic                read_en_q, read_en_d;
    logic                busy_q, busy_d;
    logic                word_done_q, word_done_d;
    logic                bit_tick;
    logic                restart;

    assign restart      = (state_d != state_q);
    assign fifo.read_en = read_en_q;
    assign tx           = tx_q;
    assign busy         = busy_q;
    assign word_done    = word_done_q;

    uart_baud_tick #(.CLKS_PER_BIT(CLKS_PER_BIT)) u_baud (
        .clk      (clk),
        .reset    (reset),
        .restart  (restart),
        .bit_tick (bit_tick)
    );

    // Next state and next output values; outputs are registered, so tx_d is
    // the line level for the first cycle of whatever state comes next.
    always_comb begin
        state_d     = state_q;
        word_d      = word_q;
        shift_d     = shift_q;
        byte_idx_d  = byte_idx_q;
        bit_idx_d   = bit_idx_q;
        tx_d        = tx_q;
        word_done_d = 1'b0;
        case (state_q)
            IDLE: begin
                if (!fifo.fifo_empty) begin
                    state_d = POP;
                end
            end
            POP: begin
                state_d = LATCH;
            end
            LATCH: begin
                word_d     = fifo.fifo_data;
                byte_idx_d = '0;
                tx_d       = 1'b0;
                state_d    = START;
            end
            START: begin
                if (bit_tick) begin
                    // The word register shifts down a byte at a time, so the
                    // current byte always sits in its low eight bits.
                    tx_d      = word_q[0];
                    shift_d   = {1'b0, word_q[7:1]};
                    word_d    = word_q >> BITS_PER_BYTE;
                    bit_idx_d = '0;
                    state_d   = DATA;
                end
            end
            DATA: begin
                if (bit_tick) begin
                    if (bit_idx_q == 3'd7) begin
                        tx_d      = 1'b1;
                        bit_idx_d = '0;
                        state_d   = STOP;
                    end else begin
                        tx_d      = shift_q[0];
                        shift_d   = {1'b0, shift_q[7:1]};
                        bit_idx_d = bit_idx_q + 3'd1;
                    end
                end
            end
            STOP: begin
                if (bit_tick) begin
                    if (bit_idx_q != LAST_STOP) begin
                        bit_idx_d = bit_idx_q + 3'd1;
                    end else if (byte_idx_q != LAST_BYTE) begin
                        byte_idx_d = byte_idx_q + BIDX_W'(1);
                        bit_idx_d  = '0;
                        tx_d       = 1'b0;
                        state_d    = START;
                    end else begin
                        bit_idx_d   = '0;
                        word_done_d = 1'b1;
                        state_d     = IDLE;
                    end
                end
            end
            default: begin
                tx_d    = 1'b1;
                state_d = IDLE;
            end
        endcase
        read_en_d = (state_d == POP);
        busy_d    = (state_d != IDLE);
    end

    // State and output registers; reset forces the line high at once and
    // drops any word in flight.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q     <= IDLE;
            word_q      <= '0;
            shift_q     <= '0;
            byte_idx_q  <= '0;
            bit_idx_q   <= '0;
            tx_q        <= 1'b1;
            read_en_q   <= 1'b0;
            busy_q      <= 1'b0;
            word_done_q <= 1'b0;
        end else begin
            state_q     <= state_d;
            word_q      <= word_d;
            shift_q     <= shift_d;
            byte_idx_q  <= byte_idx_d;
            bit_idx_q   <= bit_idx_d;
            tx_q        <= tx_d;
            read_en_q   <= read_en_d;
            busy_q      <= busy_d;
            word_done_q <= word_done_d;
        end
    end
endmodule
